store_narrower: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 36 +++
 rtl/store_lane_merge.sv | 29 ++
 rtl/store_narrower.sv | 117 +++++++++++
 tb/tb_store_narrower.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
//   Shared definitions for the MIPS32 data-memory store path.
//   - size_e  : access size encoding carried on the store size bus
//   - state_e : store_narrower FSM states
//   - req_invalid : alignment / encoding check for a store request
package mips_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_MERGE,
      ST_WRITE,
      ST_FAULT
   } state_e;

   // Reserved size, odd halfword address and unaligned word address are rejected.
   function automatic logic req_invalid(input size_e sz, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge
//   Combinational little-endian lane merge for sub-word stores.
//   Ports:
//     old_word    in  32  word currently held in memory
//     wdata       in  32  register value (truncated to the access size)
//     size        in  2   access size (size_e encoding)
//     lane        in  2   byte address bits [1:0]
//     merged_word out 32  word to write back
module store_lane_merge
   import mips_mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged_word
);

   always_comb begin
      merged_word = old_word;
      case (size_e'(size))
         SZ_BYTE: merged_word[{lane, 3'b000} +: 8]     = wdata[7:0];
         SZ_HALF: merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         SZ_WORD: merged_word = wdata;
         default: merged_word = old_word;
      endcase
   end

endmodule

// File: rtl/store_narrower.sv
// store_narrower
//   Multi-cycle sb/sh/sw unit. Byte and halfword stores do a
//   read-modify-write of the addressed memory word; word stores write
//   directly; misaligned or reserved-size requests complete with err.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     start                request strobe, sampled only in IDLE
//     size, addr, wdata    store size, byte address, register value
//     busy                 high in every state except IDLE
//     done, err            one-cycle completion / rejection pulses
//     mem_addr             latched word index addr[MEM_AW+1:2]
//     mem_rd, mem_rdata    read strobe, read data (valid the cycle after mem_rd)
//     mem_wr, mem_wdata    write strobe, merged write word
module store_narrower
   import mips_mem_pkg::*;
#(
   parameter int MEM_AW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        size,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata
);

   state_e      state;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] merged_word;

   // Address bits above the memory index are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[31:MEM_AW+2];

   store_lane_merge u_merge (
      .old_word    (mem_rdata),
      .wdata       (wdata_q),
      .size        (size_q),
      .lane        (lane_q),
      .merged_word (merged_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         size_q    <= '0;
         lane_q    <= '0;
         wdata_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         // Strobes are single-cycle; states below raise them for one cycle.
         done   <= 1'b0;
         err    <= 1'b0;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  size_q   <= size;
                  lane_q   <= addr[1:0];
                  wdata_q  <= wdata;
                  mem_addr <= addr[MEM_AW+1:2];
                  busy     <= 1'b1;
                  if (req_invalid(size_e'(size), addr[1:0])) begin
                     state <= ST_FAULT;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (size_e'(size) == SZ_WORD) begin
                     state     <= ST_WRITE;
                     mem_wr    <= 1'b1;
                     done      <= 1'b1;
                     mem_wdata <= wdata;
                  end else begin
                     state  <= ST_READ;
                     mem_rd <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               state <= ST_MERGE;
            end
            ST_MERGE: begin
               // mem_rdata is valid now, one cycle after the read strobe.
               mem_wdata <= merged_word;
               mem_wr    <= 1'b1;
               done      <= 1'b1;
               state     <= ST_WRITE;
            end
            ST_WRITE, ST_FAULT: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_narrower.sv
module tb_store_narrower;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy, done, err;
   logic [7:0]  mem_addr;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_rdata, mem_wdata;

   int vectors = 0;
   int miscompares = 0;
   int wr_count = 0;
   int rd_count = 0;
   int overlap_count = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   store_narrower #(.MEM_AW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata)
   );

   // Synchronous memory: read data valid the cycle after mem_rd.
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_rdata <= mem[mem_addr];
         rd_count  <= rd_count + 1;
      end
      if (mem_wr) begin
         mem[mem_addr] <= mem_wdata;
         wr_count      <= wr_count + 1;
      end
      if (mem_rd && mem_wr) overlap_count <= overlap_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      start = 1'b1; size = s; addr = a; wdata = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   int wr0, rd0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[0] = 32'hAAAA_BBBB;
      mem[1] = 32'h1122_3344;
      mem_rdata = '0;
      reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  {31'd0, busy},   32'd0);
      chk("rst_done",  {31'd0, done},   32'd0);
      chk("rst_err",   {31'd0, err},    32'd0);
      chk("rst_rd",    {31'd0, mem_rd}, 32'd0);
      chk("rst_wr",    {31'd0, mem_wr}, 32'd0);
      chk("rst_addr",  {24'd0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      // sb addr 6 -> lane 2 of word 1
      wr0 = wr_count;
      issue(2'b00, 32'h0000_0006, 32'hDEAD_BEEF);
      chk("sb_t1_rd",   {31'd0, mem_rd}, 32'd1);
      chk("sb_t1_wr",   {31'd0, mem_wr}, 32'd0);
      chk("sb_t1_busy", {31'd0, busy},   32'd1);
      chk("sb_t1_addr", {24'd0, mem_addr}, 32'd1);
      @(negedge clk);
      chk("sb_t2_rd",   {31'd0, mem_rd}, 32'd0);
      chk("sb_t2_done", {31'd0, done},   32'd0);
      @(negedge clk);
      chk("sb_t3_wr",    {31'd0, mem_wr}, 32'd1);
      chk("sb_t3_done",  {31'd0, done},   32'd1);
      chk("sb_t3_wdata", mem_wdata, 32'h11EF_3344);
      chk("sb_t3_addr",  {24'd0, mem_addr}, 32'd1);
      @(negedge clk);
      chk("sb_t4_done", {31'd0, done}, 32'd0);
      chk("sb_t4_busy", {31'd0, busy}, 32'd0);
      chk("sb_mem",     mem[1], 32'h11EF_3344);
      chk("sb_wrcnt",   wr_count - wr0, 32'd1);

      // sh addr 2 -> upper half of word 0
      issue(2'b01, 32'h0000_0002, 32'hFFFF_8001);
      chk("sh_t1_rd", {31'd0, mem_rd}, 32'd1);
      chk("sh_t1_addr", {24'd0, mem_addr}, 32'd0);
      repeat (2) @(negedge clk);
      chk("sh_t3_wr",    {31'd0, mem_wr}, 32'd1);
      chk("sh_t3_wdata", mem_wdata, 32'h8001_BBBB);
      @(negedge clk);
      chk("sh_mem", mem[0], 32'h8001_BBBB);

      // sw addr 0x10 -> direct write, word 4
      rd0 = rd_count;
      issue(2'b10, 32'h0000_0010, 32'h1234_5678);
      chk("sw_t1_wr",    {31'd0, mem_wr}, 32'd1);
      chk("sw_t1_done",  {31'd0, done},   32'd1);
      chk("sw_t1_rd",    {31'd0, mem_rd}, 32'd0);
      chk("sw_t1_addr",  {24'd0, mem_addr}, 32'd4);
      chk("sw_t1_wdata", mem_wdata, 32'h1234_5678);
      @(negedge clk);
      chk("sw_mem",   mem[4], 32'h1234_5678);
      chk("sw_nord",  rd_count - rd0, 32'd0);

      // Faults: sh odd, sw misaligned, reserved size
      rd0 = rd_count; wr0 = wr_count;
      issue(2'b01, 32'h0000_0003, 32'h0000_FFFF);
      chk("f_sh_done", {31'd0, done}, 32'd1);
      chk("f_sh_err",  {31'd0, err},  32'd1);
      chk("f_sh_wr",   {31'd0, mem_wr}, 32'd0);
      @(negedge clk);
      chk("f_sh_err_clr", {31'd0, err}, 32'd0);
      issue(2'b10, 32'h0000_0002, 32'h5555_5555);
      chk("f_sw_done", {31'd0, done}, 32'd1);
      chk("f_sw_err",  {31'd0, err},  32'd1);
      @(negedge clk);
      issue(2'b11, 32'h0000_0000, 32'h7777_7777);
      chk("f_rs_done", {31'd0, done}, 32'd1);
      chk("f_rs_err",  {31'd0, err},  32'd1);
      @(negedge clk);
      chk("f_nord", rd_count - rd0, 32'd0);
      chk("f_nowr", wr_count - wr0, 32'd0);

      // start re-pulsed during READ and MERGE is ignored
      mem[8] = 32'hCAFE_F00D;
      rd0 = rd_count; wr0 = wr_count;
      issue(2'b00, 32'h0000_0021, 32'h0000_0099);
      start = 1'b1; size = 2'b10; addr = 32'h0000_0040; wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rp_wdata", mem_wdata, 32'hCAFE_99_0D);
      repeat (3) @(negedge clk);
      chk("rp_wrcnt", wr_count - wr0, 32'd1);
      chk("rp_rdcnt", rd_count - rd0, 32'd1);
      chk("rp_mem8",  mem[8],  32'hCAFE_990D);
      chk("rp_mem16", mem[16], 32'd0);

      // reset during MERGE discards the request
      wr0 = wr_count;
      issue(2'b01, 32'h0000_0004, 32'h0000_ABCD);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rm_busy",  {31'd0, busy},   32'd0);
      chk("rm_done",  {31'd0, done},   32'd0);
      chk("rm_wr",    {31'd0, mem_wr}, 32'd0);
      chk("rm_rd",    {31'd0, mem_rd}, 32'd0);
      chk("rm_addr",  {24'd0, mem_addr}, 32'd0);
      chk("rm_wdata", mem_wdata, 32'd0);
      repeat (4) @(negedge clk);
      chk("rm_nowr", wr_count - wr0, 32'd0);
      chk("rm_mem1", mem[1], 32'h11EF_3344);

      chk("no_overlap", overlap_count, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
